// File: rtl/rs_syndrome_calc.sv
// RS(15,9) syndrome front end over GF(16) (x^4+x+1): Horner-evaluates r(alpha^j), j=1..N_SYN,
// over a serially received codeword (r14 first). Only WORD_WIDTH=4 is meaningful.

module rs_syn_lane #(
  parameter int                    WORD_WIDTH = 4,
  parameter logic [WORD_WIDTH-1:0] ALPHA      = 4'h2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [WORD_WIDTH-1:0] sym_in,
  output logic [WORD_WIDTH-1:0] acc
);

  // GF(16) multiply; with a constant b this folds down to a small XOR network.
  function automatic logic [WORD_WIDTH-1:0] gf_mul(input logic [WORD_WIDTH-1:0] a,
                                                   input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[WORD_WIDTH-2:0], 1'b0} ^ (x[WORD_WIDTH-1] ? WORD_WIDTH'(3) : '0);
    end
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= gf_mul(acc, ALPHA) ^ sym_in;
  end

endmodule

module rs_syndrome_calc #(
  parameter int WORD_WIDTH = 4,
  parameter int N_CODE     = 15,
  parameter int N_SYN      = 6,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             sym_valid,
  input  logic [WORD_WIDTH-1:0]            sym_in,
  output logic                             busy,
  output logic                             ready,
  output logic [N_SYN-1:0][WORD_WIDTH-1:0] syn_o,
  output logic                             err_o
);

  localparam int STAGES = 1;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  function automatic logic [WORD_WIDTH-1:0] alpha_pow(input int e);
    logic [WORD_WIDTH-1:0] p;
    p = WORD_WIDTH'(1);
    for (int i = 0; i < e; i++)
      p = {p[WORD_WIDTH-2:0], 1'b0} ^ (p[WORD_WIDTH-1] ? WORD_WIDTH'(3) : '0);
    return p;
  endfunction

  state_t                           state;
  logic [CNT_WIDTH-1:0]             cnt;
  logic [STAGES:0]                  vld_pipe;
  logic [N_SYN-1:0][WORD_WIDTH-1:0] acc;
  logic                             start_acc;
  logic                             acc_en;

  // The busy tail after DONE keeps a new start from being taken before ready fires.
  assign start_acc = start && (state == IDLE) && !busy;
  assign acc_en    = sym_valid && (state == ACC);

  for (genvar k = 0; k < N_SYN; k++) begin : g_lane
    rs_syn_lane #(
      .WORD_WIDTH (WORD_WIDTH),
      .ALPHA      (alpha_pow(k + 1))
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (start_acc),
      .en     (acc_en),
      .sym_in (sym_in),
      .acc    (acc[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      vld_pipe <= '0;
      syn_o    <= '0;
      err_o    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], state == DONE};
      case (state)
        IDLE: if (start_acc) begin
          cnt   <= '0;
          busy  <= 1'b1;
          state <= ACC;
        end
        ACC: if (sym_valid) begin
          cnt <= cnt + CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(N_CODE - 1)) state <= DONE;
        end
        DONE: begin
          syn_o <= acc;
          err_o <= |acc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (vld_pipe[0]) busy <= 1'b0;
    end
  end

  assign ready = vld_pipe[STAGES];

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Bench for rs_syndrome_calc: constant vectors, gap/start-abuse, mid-frame reset and random RS(15,9) frames.

module tb_rs_syndrome_calc;

  localparam int NC = 15;
  localparam int NS = 6;

  typedef logic [NS-1:0][3:0] syn_t;
  typedef struct {
    int         pos;
    logic [3:0] val;
    syn_t       exp_syn;
    logic       exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, start, sym_valid, busy, ready, err_o;
  logic [3:0] sym_in;
  syn_t syn_o;

  int errs = 0;
  int checks = 0;
  int ready_cnt = 0;
  logic [3:0] cw [NC];   // cw[i] = r_i

  rs_syndrome_calc #(.WORD_WIDTH(4), .N_CODE(NC), .N_SYN(NS), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sym_valid(sym_valid), .sym_in(sym_in),
    .busy(busy), .ready(ready), .syn_o(syn_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    if (ready) ready_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Field arithmetic as polynomial multiplication mod x^4+x+1.
  function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p ^= 8'(a) << i;
    for (int i = 7; i >= 4; i--) if (p[i]) p ^= 8'h13 << (i - 4);
    return p[3:0];
  endfunction

  function automatic logic [3:0] gpow(input logic [3:0] a, input int e);
    logic [3:0] p = 4'h1;
    for (int i = 0; i < e; i++) p = gmul(p, a);
    return p;
  endfunction

  // Direct evaluation S_j = sum r_i * alpha^(j*i).
  function automatic syn_t model_syn();
    syn_t s = '0;
    for (int j = 1; j <= NS; j++)
      for (int i = 0; i < NC; i++) s[j-1] ^= gmul(cw[i], gpow(4'h2, (j * i) % 15));
    return s;
  endfunction

  // Systematic encode: data in cw[6..14], parity = m(x)x^6 mod g(x).
  task automatic encode();
    logic [3:0] g [7];
    logic [3:0] r [6];
    logic [3:0] fb;
    for (int k = 0; k < 7; k++) g[k] = 4'h0;
    g[0] = 4'h1;
    for (int j = 1; j <= NS; j++) begin
      for (int k = 6; k >= 1; k--) g[k] = g[k-1] ^ gmul(g[k], gpow(4'h2, j));
      g[0] = gmul(g[0], gpow(4'h2, j));
    end
    for (int k = 0; k < 6; k++) r[k] = 4'h0;
    for (int i = NC - 1; i >= 6; i--) begin
      fb = cw[i] ^ r[5];
      for (int k = 5; k >= 1; k--) r[k] = r[k-1] ^ gmul(fb, g[k]);
      r[0] = gmul(fb, g[0]);
    end
    for (int k = 0; k < 6; k++) cw[k] = r[k];
  endtask

  task automatic run_frame(input int gap_max, input bit mid_start, input syn_t exp_syn,
                           input logic exp_err, input string nm);
    int rc0, lat;
    // sym_valid while idle must not touch the accumulators
    repeat (2) begin
      @(negedge clk);
      sym_valid = 1'b1;
      sym_in = 4'($urandom);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    rc0 = ready_cnt;
    for (int i = NC - 1; i >= 0; i--) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 1)) begin
          sym_valid = 1'b0;
          sym_in = 4'($urandom);
          start = mid_start ? 1'($urandom) : 1'b0;
          @(negedge clk);
        end
      end
      sym_valid = 1'b1;
      sym_in = cw[i];
      start = mid_start && (i % 4 == 0);
      @(negedge clk);
    end
    sym_valid = 1'b0;
    start = 1'b0;
    sym_in = 4'h0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (ready) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_syn"}, 32'(syn_o), 32'(exp_syn));
    chk({nm, "_err"}, 32'(err_o), 32'(exp_err));
    chk({nm, "_busy_at_ready"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, "_ready_pulse"}, 32'(ready), 32'd0);
    chk({nm, "_ready_count"}, 32'(ready_cnt - rc0), 32'd1);
    chk({nm, "_syn_held"}, 32'(syn_o), 32'(exp_syn));
  endtask

  initial begin
    vec_t vt [5];
    syn_t e;
    int npos;

    vt[0] = '{pos: 0,  val: 4'h0, exp_syn: 24'h000000, exp_err: 1'b0};
    vt[1] = '{pos: 0,  val: 4'h1, exp_syn: 24'h111111, exp_err: 1'b1};
    vt[2] = '{pos: 1,  val: 4'h1, exp_syn: 24'hC63842, exp_err: 1'b1};
    vt[3] = '{pos: 2,  val: 4'h1, exp_syn: 24'hF75C34, exp_err: 1'b1};
    vt[4] = '{pos: 14, val: 4'h1, exp_syn: 24'hA7EFD9, exp_err: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    sym_valid = 1'b0;
    sym_in = 4'h0;
    repeat (2) @(negedge clk);
    chk("reset_syn", 32'(syn_o), 32'd0);
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(ready), 32'd0);
    rst_n = 1'b1;

    foreach (vt[v]) begin
      for (int i = 0; i < NC; i++) cw[i] = 4'h0;
      cw[vt[v].pos] = vt[v].val;
      chk($sformatf("model_vs_table%0d", v), 32'(model_syn()), 32'(vt[v].exp_syn));
      run_frame(0, 1'b0, vt[v].exp_syn, vt[v].exp_err, $sformatf("vec%0d", v));
    end

    // r1=1 with idle gaps and stray start pulses
    for (int i = 0; i < NC; i++) cw[i] = 4'h0;
    cw[1] = 4'h1;
    run_frame(5, 1'b1, 24'hC63842, 1'b1, "gaps");

    // abort a frame with reset after 7 symbols
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sym_valid = 1'b1;
      sym_in = 4'($urandom_range(15, 1));
      @(negedge clk);
    end
    sym_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_syn", 32'(syn_o), 32'd0);
    chk("midrst_err", 32'(err_o), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NC; i++) cw[i] = 4'h0;
    cw[0] = 4'h1;
    run_frame(0, 1'b0, 24'h111111, 1'b1, "after_rst");

    // random encoded frames, odd ones carry 1-3 symbol errors
    for (int f = 0; f < 8; f++) begin
      for (int i = 6; i < NC; i++) cw[i] = 4'($urandom);
      encode();
      if (f % 2 == 0) begin
        run_frame(f % 3, 1'b0, '0, 1'b0, $sformatf("clean%0d", f));
      end else begin
        npos = $urandom_range(3, 1);
        for (int k = 0; k < npos; k++) begin
          int p;
          p = $urandom_range(NC - 1, 0);
          cw[p] = cw[p] ^ 4'($urandom_range(15, 1));
        end
        e = model_syn();
        run_frame(f % 3, 1'b0, e, |e, $sformatf("noisy%0d", f));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
